dq_burst_sched: RTL and testbench

- Burst scheduler directly upstream of the DQ SerDes array.
- Buffers controller write-data words in a small FIFO, then waits the programmed CAS write latency after each write command.
- Drives one WIDTH-bit word per mem_clk onto the SerDes wdata bus with SerDes_en/SerDes_Sel for the full burst.
- For reads, waits CAS latency, enables the SerDes in deserialize mode and returns captured rdata words with a valid strobe.

---
 rtl/dq_burst_sched.sv | 188 ++++++++++++++++++
 tb/tb_dq_burst_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dq_burst_sched.sv
// Burst scheduler feeding the DQ SerDes: buffers write data, applies CAS latency,
// then streams a write burst out or captures a read burst back.
module dq_burst_sched #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BURST_WORDS = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned LAT_W       = 6,
  parameter int unsigned TURN_CYC    = 2
) (
  input  logic                        mem_clk,
  input  logic                        rst_n,
  input  logic                        wr_cmd,
  input  logic                        rd_cmd,
  input  logic [LAT_W-1:0]            cwl,
  input  logic [LAT_W-1:0]            cl,
  input  logic                        wd_valid,
  input  logic [WIDTH-1:0]            wd_data,
  output logic                        wd_ready,
  output logic [WIDTH-1:0]            wdata,
  output logic                        SerDes_en,
  output logic                        SerDes_Sel,
  input  logic [WIDTH-1:0]            rdata_in,
  output logic                        rd_valid,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        cmd_err,
  output logic                        underrun_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int unsigned TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT, S_WR_BURST, S_RD_WAIT, S_RD_BURST, S_TURN
  } state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic              en_q, en_d, sel_q, sel_d, rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d, cmd_err_q, cmd_err_d, under_q, under_d;
  logic              ready_q, ready_d;
  logic              push, pop;
  logic [WIDTH-1:0]  mem [FIFO_DEPTH];

  // State register plus all registered outputs and FIFO bookkeeping.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      beat_q     <= '0;
      turn_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      en_q       <= 1'b0;
      sel_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      under_q    <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      turn_q     <= turn_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      cmd_err_q  <= cmd_err_d;
      under_q    <= under_d;
      ready_q    <= ready_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge mem_clk) begin
    if (push) mem[wr_ptr_q] <= wd_data;
  end

  // Next-state: latency countdown, beat counter and bus turnaround.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    turn_d  = turn_q;
    case (state_q)
      S_IDLE: begin
        if (wr_cmd) begin
          lat_d   = cwl;
          state_d = (cwl == '0) ? S_WR_BURST : S_WR_WAIT;
        end else if (rd_cmd) begin
          lat_d   = cl;
          state_d = (cl == '0) ? S_RD_BURST : S_RD_WAIT;
        end
      end
      S_WR_WAIT, S_RD_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          state_d = (state_q == S_WR_WAIT) ? S_WR_BURST : S_RD_BURST;
        end
      end
      S_WR_BURST, S_RD_BURST: begin
        if (beat_q == BW'(BURST_WORDS - 1)) begin
          beat_d = '0;
          if (TURN_CYC == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_TURN;
            turn_d  = TW'(TURN_CYC - 1);
          end
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_TURN: begin
        if (turn_q == '0) state_d = S_IDLE;
        else              turn_d  = turn_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they line up with it.
  always_comb begin
    push       = wd_valid && ready_q;
    pop        = 1'b0;
    wdata_d    = '0;
    en_d       = 1'b0;
    sel_d      = sel_q;
    under_d    = under_q;
    rd_valid_d = (state_q == S_RD_BURST);
    rd_data_d  = rd_valid_d ? rdata_in : rd_data_q;
    cmd_err_d  = (state_q == S_IDLE) ? (wr_cmd && rd_cmd) : (wr_cmd || rd_cmd);
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_WR_BURST: begin
        en_d  = 1'b1;
        sel_d = 1'b1;
        if (level_q != '0) begin
          pop     = 1'b1;
          wdata_d = mem[rd_ptr_q];
        end else begin
          under_d = 1'b1;
        end
      end
      S_RD_BURST: begin
        en_d  = 1'b1;
        sel_d = 1'b0;
      end
      default: begin
        en_d = 1'b0;
      end
    endcase
    level_d  = level_q + LW'(push) - LW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    ready_d  = (level_d != LW'(FIFO_DEPTH));
  end

  assign wd_ready     = ready_q;
  assign wdata        = wdata_q;
  assign SerDes_en    = en_q;
  assign SerDes_Sel   = sel_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign fifo_level   = level_q;
  assign cmd_err      = cmd_err_q;
  assign underrun_err = under_q;

endmodule

// File: tb/tb_dq_burst_sched.sv
// Scoreboard bench for dq_burst_sched: a window-based reference model queues
// per-cycle expectations; a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_dq_burst_sched;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned BURST_WORDS = 8;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned LAT_W       = 6;
  localparam int unsigned TURN_CYC    = 2;

  logic                        mem_clk;
  logic                        rst_n;
  logic                        wr_cmd, rd_cmd;
  logic [LAT_W-1:0]            cwl, cl;
  logic                        wd_valid;
  logic [WIDTH-1:0]            wd_data;
  logic                        wd_ready;
  logic [WIDTH-1:0]            wdata;
  logic                        SerDes_en, SerDes_Sel;
  logic [WIDTH-1:0]            rdata_in;
  logic                        rd_valid;
  logic [WIDTH-1:0]            rd_data;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        cmd_err, underrun_err;

  dq_burst_sched #(
    .WIDTH(WIDTH), .BURST_WORDS(BURST_WORDS), .FIFO_DEPTH(FIFO_DEPTH),
    .LAT_W(LAT_W), .TURN_CYC(TURN_CYC)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
    .cwl(cwl), .cl(cl), .wd_valid(wd_valid), .wd_data(wd_data),
    .wd_ready(wd_ready), .wdata(wdata), .SerDes_en(SerDes_en),
    .SerDes_Sel(SerDes_Sel), .rdata_in(rdata_in), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .fifo_level(fifo_level),
    .cmd_err(cmd_err), .underrun_err(underrun_err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int cyc = 0;
  always @(posedge mem_clk) cyc <= cyc + 1;

  typedef struct { int cyc; bit sel; logic [WIDTH-1:0] data; } beat_t;
  typedef struct { int cyc; logic [WIDTH-1:0] data; } rd_t;
  typedef struct { int cyc; int level; bit busy; bit under; } st_t;

  beat_t            exp_b[$];
  rd_t              exp_r[$];
  int               exp_e[$];
  st_t              exp_s[$];
  logic [WIDTH-1:0] mq[$];

  int idle_from, busy_from, bstart, bend;
  bit bwr, under;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_b.delete(); exp_r.delete(); exp_e.delete(); exp_s.delete(); mq.delete();
    idle_from = 0; busy_from = 0; bstart = -100; bend = -100; bwr = 1'b0; under = 1'b0;
  endtask

  // One cycle of stimulus; model projects the DUT's visible state for the next cycle.
  task automatic step(input bit wr, input bit rd, input int lat, input bit pv,
                      input logic [WIDTH-1:0] pd);
    int    c;
    bit    rdy;
    beat_t b;
    rd_t   r;
    st_t   s;
    @(negedge mem_clk);
    c = cyc;
    wr_cmd = wr; rd_cmd = rd;
    cwl = LAT_W'(lat); cl = LAT_W'(lat);
    wd_valid = pv; wd_data = pd;
    rdata_in = $urandom();
    if (wr || rd) begin
      if (c >= idle_from) begin
        bwr       = wr;
        bstart    = c + lat + 1;
        bend      = bstart + BURST_WORDS - 1;
        busy_from = c + 1;
        idle_from = bend + TURN_CYC + 1;
        if (wr && rd) exp_e.push_back(c + 1);
      end else begin
        exp_e.push_back(c + 1);
      end
    end
    if (!bwr && c >= bstart && c <= bend) begin
      r.cyc = c + 1; r.data = rdata_in;
      exp_r.push_back(r);
    end
    rdy = (mq.size() != FIFO_DEPTH);
    if (c + 1 >= bstart && c + 1 <= bend) begin
      b.cyc = c + 1; b.sel = bwr; b.data = '0;
      if (bwr) begin
        if (mq.size() > 0) b.data = mq.pop_front();
        else               under  = 1'b1;
      end
      exp_b.push_back(b);
    end
    if (pv && rdy) mq.push_back(pd);
    s.cyc = c + 1; s.level = mq.size();
    s.busy = (c + 1 >= busy_from) && (c + 1 < idle_from);
    s.under = under;
    exp_s.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic do_reset(input int hold);
    st_t s;
    @(negedge mem_clk);
    rst_n = 1'b0; wr_cmd = 1'b0; rd_cmd = 1'b0; wd_valid = 1'b0;
    #1;
    chk("rst_serdes_en",  64'(SerDes_en), 64'(0));
    chk("rst_serdes_sel", 64'(SerDes_Sel), 64'(0));
    chk("rst_wdata",      64'(wdata), 64'(0));
    chk("rst_rd_valid",   64'(rd_valid), 64'(0));
    chk("rst_rd_data",    64'(rd_data), 64'(0));
    chk("rst_cmd_err",    64'(cmd_err), 64'(0));
    chk("rst_underrun",   64'(underrun_err), 64'(0));
    chk("rst_busy",       64'(busy), 64'(0));
    chk("rst_fifo_level", 64'(fifo_level), 64'(0));
    model_clear();
    repeat (hold) @(negedge mem_clk);
    rst_n = 1'b1;
    s.cyc = cyc + 1; s.level = 0; s.busy = 1'b0; s.under = 1'b0;
    exp_s.push_back(s);
  endtask

  // Monitor: compare DUT outputs against whatever the model queued for this cycle.
  initial begin
    st_t s;
    beat_t b;
    rd_t r;
    forever begin
      @(posedge mem_clk);
      #1;
      if (rst_n) begin
        if (exp_s.size() > 0) begin
          s = exp_s.pop_front();
          chk("fifo_level", 64'(fifo_level), 64'(s.level));
          chk("wd_ready",   64'(wd_ready), 64'(s.level != FIFO_DEPTH));
          chk("busy",       64'(busy), 64'(s.busy));
          chk("underrun",   64'(underrun_err), 64'(s.under));
        end else begin
          checks++; failures++;
          $display("FAIL status_expectation cyc=%0d actual=none expected=one", cyc);
        end
        if (exp_b.size() > 0 && exp_b[0].cyc == cyc) begin
          b = exp_b.pop_front();
          chk("beat_en",    64'(SerDes_en), 64'(1));
          chk("beat_sel",   64'(SerDes_Sel), 64'(b.sel));
          chk("beat_wdata", 64'(wdata), 64'(b.data));
        end else begin
          chk("idle_en",    64'(SerDes_en), 64'(0));
          chk("idle_wdata", 64'(wdata), 64'(0));
        end
        if (exp_r.size() > 0 && exp_r[0].cyc == cyc) begin
          r = exp_r.pop_front();
          chk("rd_valid", 64'(rd_valid), 64'(1));
          chk("rd_data",  64'(rd_data), 64'(r.data));
        end else begin
          chk("rd_valid_idle", 64'(rd_valid), 64'(0));
        end
        if (exp_e.size() > 0 && exp_e[0] == cyc) begin
          void'(exp_e.pop_front());
          chk("cmd_err", 64'(cmd_err), 64'(1));
        end else begin
          chk("cmd_err_idle", 64'(cmd_err), 64'(0));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_cmd = 1'b0; rd_cmd = 1'b0; cwl = '0; cl = '0;
    wd_valid = 1'b0; wd_data = '0; rdata_in = '0;
    model_clear();
    do_reset(3);

    // Basic write, cwl=4
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, 32'h1000_0000 + 32'(i));
    step(1'b1, 1'b0, 4, 1'b0, '0);
    idle(16);

    // Zero latency with only three words queued
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 32'h2000_0000 + 32'(i));
    step(1'b1, 1'b0, 0, 1'b0, '0);
    idle(14);
    do_reset(2);

    // Basic read, cl=3
    step(1'b0, 1'b1, 3, 1'b0, '0);
    idle(16);

    // Collision, then a read dropped during the write wait
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, 32'h4000_0000 + 32'(i));
    step(1'b1, 1'b1, 5, 1'b0, '0);
    step(1'b0, 1'b0, 0, 1'b0, '0);
    step(1'b0, 1'b1, 2, 1'b0, '0);
    idle(20);

    // Fill past full, then drain across the pointer wrap while refilling
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 1'b1, 32'h3000_0000 + 32'(i));
    step(1'b1, 1'b0, 1, 1'b1, 32'h3100_0000);
    for (int i = 1; i < 14; i++) step(1'b0, 1'b0, 0, 1'b1, 32'h3100_0000 + 32'(i));
    step(1'b1, 1'b0, 0, 1'b0, '0);
    idle(12);
    step(1'b1, 1'b0, 2, 1'b0, '0);
    idle(14);

    // Reset during the third beat of a write burst
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, 32'h5000_0000 + 32'(i));
    step(1'b1, 1'b0, 2, 1'b0, '0);
    idle(4);
    do_reset(2);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      automatic bit w  = ($urandom_range(11) == 0);
      automatic bit rd = ($urandom_range(11) == 0);
      automatic int l  = ($urandom_range(7) == 0) ? int'($urandom_range(63)) : int'($urandom_range(5));
      automatic bit pv = ($urandom_range(2) != 0);
      step(w, rd, l, pv, $urandom());
    end
    idle(90);

    chk("beats_left", 64'(exp_b.size()), 64'(0));
    chk("reads_left", 64'(exp_r.size()), 64'(0));
    chk("errs_left",  64'(exp_e.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
